// File: rtl/sprite_frame_scheduler.sv
// sprite_frame_scheduler
// Latches player position/state updates from game logic over a 4-phase
// req/ack handshake and commits them on the rising edge of vblank, so the
// renderer never sees a half-updated frame. Also sequences per-player
// animation frames and counts frames.
//
// Optional feature macro: DROPPED_FRAME_CNT_EN
//   defined   -> dropped_frames counts frames on which no commit could happen
//                (saturating at 255, cleared only by reset)
//   undefined -> dropped_frames is tied to zero

module sprite_frame_scheduler #(
  parameter int ANIM_DIV    = 8,
  parameter int ANIM_FRAMES = 4,
  parameter int X_MAX       = 640,
  parameter int Y_MAX       = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblank,
  input  logic        upd_req,
  output logic        upd_ack,
  input  logic [9:0]  in_p1_x,
  input  logic [9:0]  in_p1_y,
  input  logic [9:0]  in_p2_x,
  input  logic [9:0]  in_p2_y,
  input  logic [3:0]  in_p1_state,
  input  logic [3:0]  in_p2_state,
  output logic [9:0]  p1_x,
  output logic [9:0]  p1_y,
  output logic [9:0]  p2_x,
  output logic [9:0]  p2_y,
  output logic [3:0]  p1_state,
  output logic [3:0]  p2_state,
  output logic [1:0]  p1_anim,
  output logic [1:0]  p2_anim,
  output logic        frame_tick,
  output logic [15:0] frame_count,
  output logic [7:0]  dropped_frames
);

  localparam int               DIV_W     = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(ANIM_DIV - 1);
  localparam logic [1:0]       ANIM_LAST = 2'(ANIM_FRAMES - 1);
  localparam logic [9:0]       X_LIM     = 10'(X_MAX - 1);
  localparam logic [9:0]       Y_LIM     = 10'(Y_MAX - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ACK     = 2'd2
  } fsm_t;

  fsm_t             fsm_state;
  logic             vblank_q;
  logic             frame_edge;
  logic             commit;
  logic             anim_step;
  logic             p1_changed;
  logic             p2_changed;
  logic [DIV_W-1:0] div_cnt;

  // A request that is already pending when vblank rises gets committed;
  // one that only arrives on the edge cycle has to wait for the next frame.
  assign frame_edge = vblank & ~vblank_q;
  assign commit     = (fsm_state == PENDING) & upd_req & frame_edge;
  assign anim_step  = frame_edge & (div_cnt == DIV_LAST);
  assign p1_changed = commit & (in_p1_state != p1_state);
  assign p2_changed = commit & (in_p2_state != p2_state);

  function automatic logic [9:0] clamp(input logic [9:0] v, input logic [9:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // State 0 loops through the frames, state 1 (jump) plays once and holds the
  // last frame, any other state shows frame 0. A state change restarts at 0.
  function automatic logic [1:0] next_anim(input logic [1:0] cur, input logic [3:0] st,
                                           input logic changed, input logic step);
    logic [1:0] nxt;
    nxt = cur;
    if (changed) begin
      nxt = 2'd0;
    end else if (step) begin
      case (st)
        4'd0:    nxt = (cur == ANIM_LAST) ? 2'd0 : cur + 2'd1;
        4'd1:    nxt = (cur == ANIM_LAST) ? cur  : cur + 2'd1;
        default: nxt = 2'd0;
      endcase
    end
    return nxt;
  endfunction

  // Frame edge detection, frame tick pulse, frame counter and animation divider.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblank_q    <= 1'b0;
      frame_tick  <= 1'b0;
      frame_count <= 16'd0;
      div_cnt     <= '0;
    end else begin
      vblank_q   <= vblank;
      frame_tick <= frame_edge;
      if (frame_edge) begin
        frame_count <= frame_count + 16'd1;
        div_cnt     <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      end
    end
  end

  // Handshake FSM; loads the clamped shadow registers on commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_state <= IDLE;
      upd_ack   <= 1'b0;
      p1_x      <= 10'd0;
      p1_y      <= 10'd0;
      p2_x      <= 10'd0;
      p2_y      <= 10'd0;
      p1_state  <= 4'd0;
      p2_state  <= 4'd0;
    end else begin
      case (fsm_state)
        IDLE: begin
          if (upd_req) fsm_state <= PENDING;
        end
        PENDING: begin
          if (!upd_req) begin
            fsm_state <= IDLE;
          end else if (frame_edge) begin
            p1_x      <= clamp(in_p1_x, X_LIM);
            p1_y      <= clamp(in_p1_y, Y_LIM);
            p2_x      <= clamp(in_p2_x, X_LIM);
            p2_y      <= clamp(in_p2_y, Y_LIM);
            p1_state  <= in_p1_state;
            p2_state  <= in_p2_state;
            upd_ack   <= 1'b1;
            fsm_state <= ACK;
          end
        end
        ACK: begin
          if (!upd_req) begin
            upd_ack   <= 1'b0;
            fsm_state <= IDLE;
          end
        end
        default: begin
          upd_ack   <= 1'b0;
          fsm_state <= IDLE;
        end
      endcase
    end
  end

  // Per-player animation frame sequencing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_anim <= 2'd0;
      p2_anim <= 2'd0;
    end else begin
      p1_anim <= next_anim(p1_anim, p1_state, p1_changed, anim_step);
      p2_anim <= next_anim(p2_anim, p2_state, p2_changed, anim_step);
    end
  end

`ifdef DROPPED_FRAME_CNT_EN
  // Count frames on which nothing could be committed, saturating at 255.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dropped_frames <= 8'd0;
    end else if (frame_edge && (fsm_state == IDLE || fsm_state == ACK) &&
                 dropped_frames != 8'hFF) begin
      dropped_frames <= dropped_frames + 8'd1;
    end
  end
`else
  assign dropped_frames = 8'd0;
`endif

endmodule

// File: doc/sprite_frame_scheduler.md
Name: sprite_frame_scheduler

Overview:
- Sits between game logic and the graphics renderer.
- Takes player position and state updates through a 4-phase req/ack handshake.
- Commits them atomically on the rising edge of vertical blanking, so a frame is never drawn with half-updated sprite data.
- Runs per-player animation frame sequencing; the resulting frame indices select sprite image lookups in the renderer.

Parameters:
- ANIM_DIV, 8: number of displayed frames per animation step; must be ≥1.
- ANIM_FRAMES, 4: number of animation frames per sprite state; must be 1..4.
- X_MAX, 640: horizontal clamp bound; committed x is clamped to ≤ X_MAX-1.
- Y_MAX, 480: vertical clamp bound; committed y is clamped to ≤ Y_MAX-1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- vblank  in  1  vertical-blank level from the VGA controller, synchronous to clk
- upd_req  in  1  game logic update request (4-phase handshake)
- upd_ack  out  1  update committed; held high until upd_req falls
- in_p1_x, in_p1_y  in  10 each  requested player 1 position
- in_p2_x, in_p2_y  in  10 each  requested player 2 position
- in_p1_state, in_p2_state  in  4 each  requested player states (0 = standing, 1 = jump)
- p1_x, p1_y, p2_x, p2_y  out  10 each  committed (shadow) positions to the renderer
- p1_state, p2_state  out  4 each  committed states
- p1_anim, p2_anim  out  2 each  current animation frame index
- frame_tick  out  1  one-cycle pulse per frame
- frame_count  out  16  frames elapsed since reset
- dropped_frames  out  8  frames with no update (see Optional Feature)

Behaviour:
- **Clock and reset.** rst is asynchronous, active-low; clk is the clock. While rst=0, every output register is 0: positions, states, anim, upd_ack, frame_tick, frame_count, dropped_frames, and FSM = IDLE.
- **Frame edge.**
  - vblank_q is a registered copy of vblank.
  - edge = vblank & ~vblank_q.
  - frame_tick is the registered edge: it goes high exactly one cycle after the vblank rise and stays high for one cycle.
  - frame_count increments on each edge and wraps 0xFFFF→0.
- **Handshake FSM** (states IDLE, PENDING, ACK):
  - IDLE → PENDING when upd_req=1. A request arriving in the same cycle as an edge does not commit on that edge; it waits for the next frame.
  - In PENDING:
    - If upd_req=0, return to IDLE with no commit (withdrawn request).
    - If edge=1 and upd_req=1, load all shadow registers from the in_* ports and go to ACK.
  - ACK: upd_ack=1 (registered, asserted starting the cycle after commit). When upd_req=0, go to IDLE with upd_ack=0 on the next cycle.
  - Game logic holds the in_* ports stable from upd_req rise until upd_ack rise.
- **Clamping at commit.**
  - x_out = (in_x > X_MAX-1) ? X_MAX-1 : in_x.
  - Same rule for y with Y_MAX.
  - Unsigned 10-bit compare; no wrap.
- **Animation.**
  - div_cnt counts 0..ANIM_DIV-1 on each edge and wraps. step = edge & (div_cnt == ANIM_DIV-1).
  - Per player, priority order:
    1. A commit whose new state differs from the current committed state → anim = 0.
    2. Otherwise, on step:
       - state 0: anim = (anim == ANIM_FRAMES-1) ? 0 : anim+1 (loops).
       - state 1: anim increments and saturates at ANIM_FRAMES-1 (no loop).
       - any other state: anim = 0.
  - A commit with an unchanged state does not reset anim.
  - A commit and a step in the same cycle with a changed state → anim = 0.
- **Reset mid-operation** (e.g. in PENDING or ACK): the FSM returns to IDLE, upd_ack is 0, no commit takes place, and the shadow registers are cleared to 0.

Optional Feature:
- Macro: DROPPED_FRAME_CNT_EN.
- Defined:
  - dropped_frames is an 8-bit saturating counter.
  - It increments on each edge where the FSM is IDLE or ACK, i.e. no commit was possible on that frame.
  - It saturates at 255.
  - It clears only on reset.
- Not defined: dropped_frames is tied to 8'd0 and no counter logic is synthesised.

Test Plan:
1. **Reset.** Hold rst=0 for 5 cycles with random inputs → all outputs 0. Release, then drive vblank 0→1 → frame_tick pulses 1 cycle, 1 cycle after the vblank rise, and frame_count=1.
2. **Commit on vblank.** Raise upd_req with in_p1_x=100, in_p1_y=200, in_p1_state=0 while vblank=0 → p1_x stays 0 and upd_ack stays 0 until the vblank rise. On that edge p1_x=100 and p1_y=200; upd_ack=1 the next cycle. Drop upd_req → upd_ack=0 one cycle later.
3. **Clamp.** Commit in_p2_x=700, in_p2_y=1023 → p2_x=639, p2_y=479. Commit in_p2_x=639 → unchanged 639.
4. **Withdrawn and simultaneous requests.**
   - upd_req high for 3 cycles, then low before any vblank → no commit, upd_ack never high.
   - upd_req rising on the same cycle as an edge → commit occurs on the following edge, not the current one.
5. **Animation, ANIM_DIV=2, ANIM_FRAMES=4.**
   - State 0: p1_anim goes 0,1,2,3,0 at edges 2,4,6,8,10.
   - Commit state 1 at edge 5 → p1_anim=0, then 1,2,3,3 at subsequent steps (saturates).
   - Recommit state 1 → anim not reset.
6. **DROPPED_FRAME_CNT_EN.**
   - Defined: 300 edges with no request → dropped_frames=255. One commit frame → does not increment.
   - Not defined: dropped_frames stays 0.
